// File: rtl/serial_port_sfr.sv
// SFR-side controller for the 8051 serial port: holds SCON and SBUF, launches
// UART transmits, latches received bytes, and raises the TI/RI interrupt flags.
module serial_port_sfr #(
    parameter logic [7:0] SCON_ADDR = 8'h98,
    parameter logic [7:0] SBUF_ADDR = 8'h99
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_sfr_addr,
    input  logic [7:0] i_sfr_wdata,
    input  logic       i_sfr_we,
    input  logic       i_sfr_re,
    output logic [7:0] o_sfr_rdata,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_done,
    output logic       o_rx_en,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    output logic       o_irq,
    output logic       o_rx_overrun
);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_BUSY,
        TX_DONE
    } tx_state_e;

    localparam int RI_BIT  = 0;
    localparam int TI_BIT  = 1;
    localparam int RB8_BIT = 2;
    localparam int REN_BIT = 4;

    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] scon_q, scon_d;
    logic [7:0] sbuf_rx_q, sbuf_rx_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] rdata_q, rdata_d;
    logic       irq_q, irq_d;
    logic       overrun_q, overrun_d;
    logic       tx_done_prev_q, tx_done_prev_d;
    logic       rx_done_prev_q, rx_done_prev_d;

    logic tx_rise, rx_rise;
    logic scon_wr, sbuf_wr;
    logic rx_accept, rx_overrun_set;

    always_comb begin
        // NOTE: every signal is given a default before any branch so no latch is inferred.
        tx_state_d     = tx_state_q;
        scon_d         = scon_q;
        sbuf_rx_d      = sbuf_rx_q;
        tx_data_d      = tx_data_q;
        rdata_d        = rdata_q;
        overrun_d      = overrun_q;
        tx_done_prev_d = i_tx_done;
        rx_done_prev_d = i_rx_done;

        tx_rise        = i_tx_done & ~tx_done_prev_q;
        rx_rise        = i_rx_done & ~rx_done_prev_q;
        scon_wr        = i_sfr_we && (i_sfr_addr == SCON_ADDR);
        sbuf_wr        = i_sfr_we && (i_sfr_addr == SBUF_ADDR);
        rx_accept      = rx_rise & scon_q[REN_BIT] & ~scon_q[RI_BIT];
        rx_overrun_set = rx_rise & scon_q[REN_BIT] &  scon_q[RI_BIT];

        unique case (tx_state_q)
            TX_IDLE: begin
                if (sbuf_wr) begin
                    tx_data_d  = i_sfr_wdata;
                    tx_state_d = TX_START;
                end
            end
            TX_START: tx_state_d = TX_BUSY;
            TX_BUSY:  if (tx_rise) tx_state_d = TX_DONE;
            TX_DONE:  tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase

        // Software write first, hardware updates after it so a flag set wins.
        if (scon_wr) scon_d = i_sfr_wdata;
        if (tx_state_q == TX_DONE) scon_d[TI_BIT] = 1'b1;
        if (rx_accept) begin
            sbuf_rx_d       = i_rx_data;
            scon_d[RI_BIT]  = 1'b1;
            scon_d[RB8_BIT] = 1'b0;
        end

        if (scon_wr && !i_sfr_wdata[RI_BIT]) overrun_d = 1'b0;
        if (rx_overrun_set) overrun_d = 1'b1;

        if (i_sfr_re) begin
            if (i_sfr_addr == SCON_ADDR)      rdata_d = scon_q;
            else if (i_sfr_addr == SBUF_ADDR) rdata_d = sbuf_rx_q;
            else                              rdata_d = 8'h00;
        end

        irq_d = scon_q[TI_BIT] | scon_q[RI_BIT];
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments only.
        if (i_rst) begin
            tx_state_q     <= TX_IDLE;
            scon_q         <= 8'h00;
            sbuf_rx_q      <= 8'h00;
            tx_data_q      <= 8'h00;
            rdata_q        <= 8'h00;
            irq_q          <= 1'b0;
            overrun_q      <= 1'b0;
            // Reset high so a done level already present at release is not an edge.
            tx_done_prev_q <= 1'b1;
            rx_done_prev_q <= 1'b1;
        end else begin
            tx_state_q     <= tx_state_d;
            scon_q         <= scon_d;
            sbuf_rx_q      <= sbuf_rx_d;
            tx_data_q      <= tx_data_d;
            rdata_q        <= rdata_d;
            irq_q          <= irq_d;
            overrun_q      <= overrun_d;
            tx_done_prev_q <= tx_done_prev_d;
            rx_done_prev_q <= rx_done_prev_d;
        end
    end

    assign o_sfr_rdata  = rdata_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = (tx_state_q == TX_START);
    assign o_rx_en      = scon_q[REN_BIT];
    assign o_irq        = irq_q;
    assign o_rx_overrun = overrun_q;

endmodule

// File: tb/tb_serial_port_sfr.sv
// Scoreboard bench for serial_port_sfr: reads and transmit launches queue their
// expected values; a negedge monitor pops and compares when the DUT presents them.
module tb_serial_port_sfr;

    localparam logic [7:0] SCON = 8'h98;
    localparam logic [7:0] SBUF = 8'h99;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_sfr_addr;
    logic [7:0] i_sfr_wdata;
    logic       i_sfr_we;
    logic       i_sfr_re;
    logic [7:0] o_sfr_rdata;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       i_tx_done;
    logic       o_rx_en;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       o_irq;
    logic       o_rx_overrun;

    int checks = 0;
    int passes = 0;
    int start_count = 0;
    logic rd_pend = 1'b0;

    logic [7:0] exp_rd[$];
    string      exp_rd_name[$];
    logic [7:0] exp_tx[$];

    serial_port_sfr dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_sfr_addr   (i_sfr_addr),
        .i_sfr_wdata  (i_sfr_wdata),
        .i_sfr_we     (i_sfr_we),
        .i_sfr_re     (i_sfr_re),
        .o_sfr_rdata  (o_sfr_rdata),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (i_tx_done),
        .o_rx_en      (o_rx_en),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .o_irq        (o_irq),
        .o_rx_overrun (o_rx_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // A read strobe sampled at a posedge means o_sfr_rdata is valid afterwards.
    always @(posedge i_clk) rd_pend <= i_sfr_re && !i_rst;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (rd_pend) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read", o_sfr_rdata, 8'hxx);
                end else begin
                    check(exp_rd_name.pop_front(), o_sfr_rdata, exp_rd.pop_front());
                end
            end
            if (o_tx_start) begin
                start_count++;
                if (exp_tx.size() == 0) check("unexpected_tx_start", o_tx_data, 8'hxx);
                else check("tx_data_at_start", o_tx_data, exp_tx.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
        i_sfr_addr  = addr;
        i_sfr_wdata = data;
        i_sfr_we    = 1'b1;
        tick();
        i_sfr_we    = 1'b0;
    endtask

    task automatic sfr_read(input logic [7:0] addr, input logic [7:0] exp, input string name);
        exp_rd.push_back(exp);
        exp_rd_name.push_back(name);
        i_sfr_addr = addr;
        i_sfr_re   = 1'b1;
        tick();
        i_sfr_re   = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] data);
        i_rx_data = data;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1; i_sfr_addr = 8'h00; i_sfr_wdata = 8'h00;
        i_sfr_we = 1'b0; i_sfr_re = 1'b0;
        i_tx_done = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
        repeat (3) tick();
        i_rst = 1'b0;

        // Reset state
        check("reset_irq", {7'd0, o_irq}, 8'h00);
        check("reset_tx_start", {7'd0, o_tx_start}, 8'h00);
        check("reset_overrun", {7'd0, o_rx_overrun}, 8'h00);
        sfr_read(SCON, 8'h00, "reset_scon");
        sfr_read(SBUF, 8'h00, "reset_sbuf");
        sfr_read(8'h42, 8'h00, "unmapped_addr");

        // Basic transmit
        exp_tx.push_back(8'hA5);
        sfr_write(SBUF, 8'hA5);
        check("tx_start_high", {7'd0, o_tx_start}, 8'h01);
        check("tx_data_a5", o_tx_data, 8'hA5);
        tick();
        check("tx_start_one_cycle", {7'd0, o_tx_start}, 8'h00);
        repeat (20) tick();
        i_tx_done = 1'b1;
        tick();
        tick();
        check("irq_lags_ti", {7'd0, o_irq}, 8'h00);
        sfr_read(SCON, 8'h02, "ti_set");
        check("irq_after_ti", {7'd0, o_irq}, 8'h01);
        i_tx_done = 1'b0;
        sfr_write(SCON, 8'h00);
        tick();
        check("irq_cleared", {7'd0, o_irq}, 8'h00);
        sfr_read(SCON, 8'h00, "ti_cleared");

        // SBUF write while busy is dropped
        exp_tx.push_back(8'h11);
        sfr_write(SBUF, 8'h11);
        tick();
        sfr_write(SBUF, 8'h22);
        repeat (3) tick();
        check("tx_data_held", o_tx_data, 8'h11);
        i_tx_done = 1'b1;
        tick();
        tick();
        i_tx_done = 1'b0;
        sfr_read(SCON, 8'h02, "ti_second_tx");
        sfr_write(SCON, 8'h00);

        // Receive and overrun
        sfr_write(SCON, 8'h10);
        check("rx_en_on", {7'd0, o_rx_en}, 8'h01);
        pulse_rx(8'h3C);
        sfr_read(SBUF, 8'h3C, "rx_byte");
        sfr_read(SCON, 8'h11, "ri_set");
        check("irq_ri", {7'd0, o_irq}, 8'h01);
        check("no_overrun_yet", {7'd0, o_rx_overrun}, 8'h00);
        pulse_rx(8'h55);
        check("overrun_set", {7'd0, o_rx_overrun}, 8'h01);
        sfr_read(SBUF, 8'h3C, "rx_byte_kept");
        sfr_write(SCON, 8'h10);
        check("overrun_cleared", {7'd0, o_rx_overrun}, 8'h00);
        sfr_read(SCON, 8'h10, "ri_cleared");

        // REN=0 ignores receive edges
        sfr_write(SCON, 8'h00);
        check("rx_en_off", {7'd0, o_rx_en}, 8'h00);
        pulse_rx(8'h77);
        sfr_read(SCON, 8'h00, "ri_stays_0");
        sfr_read(SBUF, 8'h3C, "rx_ignored");

        // Reset during transmit
        exp_tx.push_back(8'h5A);
        sfr_write(SBUF, 8'h5A);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_tx_done = 1'b1;
        repeat (3) tick();
        i_tx_done = 1'b0;
        sfr_read(SCON, 8'h00, "ti_after_reset");
        sfr_read(SBUF, 8'h00, "sbuf_after_reset");
        check("irq_after_reset", {7'd0, o_irq}, 8'h00);
        exp_tx.push_back(8'hC3);
        sfr_write(SBUF, 8'hC3);
        check("relaunch_start", {7'd0, o_tx_start}, 8'h01);
        check("relaunch_data", o_tx_data, 8'hC3);

        // SCON write of 0 coincides with TI hardware set: set wins
        tick();
        i_tx_done = 1'b1;
        tick();
        sfr_write(SCON, 8'h00);
        i_tx_done = 1'b0;
        sfr_read(SCON, 8'h02, "ti_set_wins");

        repeat (3) tick();
        check("reads_drained", 8'(exp_rd.size()), 8'h00);
        check("tx_drained", 8'(exp_tx.size()), 8'h00);
        check("tx_start_count", 8'(start_count), 8'h04);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
